// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential signed restoring divider.
package seq_divider_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   // Iteration counter width for a W-bit divider.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   // Magnitude of a sign-extended operand, one bit wider so -2^(n-1) survives.
   function automatic logic [MAX_W:0] abs_ext(input logic [MAX_W-1:0] x);
      logic [MAX_W:0] ext;
      ext = {x[MAX_W-1], x};
      return x[MAX_W-1] ? (~ext + (MAX_W+1)'(1)) : ext;
   endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// Combinational (W+1)-bit subtractor: diff = a - b, borrow set when a < b.
module seq_divider_addsub #(
   parameter int unsigned W = 5
) (
   input  logic [W:0] a,
   input  logic [W:0] b,
   output logic [W:0] diff,
   output logic       borrow
);

   logic [W+1:0] full;

   assign full   = {1'b0, a} - {1'b0, b};
   assign diff   = full[W:0];
   assign borrow = full[W+1];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed radix-2 restoring divider, W+1 clocks per operation.
// Optional divide-by-zero reporting is enabled by SEQ_DIVIDER_DBZ_DETECT_EN.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quot,
   output logic [W-1:0] rem,
   output logic         busy,
   output logic         done,
   output logic         dbz
);

   localparam int unsigned CNT_W = cnt_width(W);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [W:0]       p_q, p_d;
   logic [W:0]       dvs_q, dvs_d;
   logic [W-1:0]     q_q, q_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [W-1:0]     quot_q, quot_d;
   logic [W-1:0]     rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [W:0]       p_sh;
   logic [W:0]       diff;
   logic             borrow;

`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
   logic             zdiv_q, zdiv_d;
   logic [W-1:0]     dvd_q, dvd_d;
   logic             dbz_q, dbz_d;
`endif

   // Partial remainder shifted left with the next dividend bit brought in.
   assign p_sh = (W+1)'({p_q, q_q[W-1]});

   seq_divider_addsub #(.W(W)) u_addsub (
      .a      (p_sh),
      .b      (dvs_q),
      .diff   (diff),
      .borrow (borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         p_q     <= '0;
         dvs_q   <= '0;
         q_q     <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
         zdiv_q  <= 1'b0;
         dvd_q   <= '0;
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         p_q     <= p_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
         zdiv_q  <= zdiv_d;
         dvd_q   <= dvd_d;
         dbz_q   <= dbz_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      p_d     = p_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
      zdiv_d  = zdiv_q;
      dvd_d   = dvd_q;
      dbz_d   = dbz_q;
`endif

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = ITER;
               count_d = '0;
               p_d     = '0;
               q_d     = W'(abs_ext(MAX_W'(signed'(dividend))));
               dvs_d   = (W+1)'(abs_ext(MAX_W'(signed'(divisor))));
               neg_q_d = dividend[W-1] ^ divisor[W-1];
               neg_r_d = dividend[W-1];
               busy_d  = 1'b1;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
               zdiv_d  = (divisor == '0);
               dvd_d   = dividend;
`endif
            end
         end

         ITER: begin
            busy_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
            p_d     = borrow ? p_sh : diff;
            q_d     = {q_q[W-2:0], ~borrow};
            if (count_q == CNT_W'(W - 1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            quot_d  = neg_q_q ? (~q_q + W'(1)) : q_q;
            rem_d   = neg_r_q ? (~p_q[W-1:0] + W'(1)) : p_q[W-1:0];
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
            dbz_d   = zdiv_q;
            if (zdiv_q) begin
               quot_d = '1;
               rem_d  = dvd_q;
            end
`endif
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign quot = quot_q;
   assign rem  = rem_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
   assign dbz  = dbz_q;
`else
   assign dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, scoreboard, corner sequences.
module tb_seq_divider;

   localparam int unsigned W = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quot;
   logic [W-1:0] rem;
   logic         busy;
   logic         done;
   logic         dbz;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      bit           chk_qr;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[14];
   int   checks   = 0;
   int   failures = 0;
   int   dones    = 0;

   seq_divider #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .quot     (quot),
      .rem      (rem),
      .busy     (busy),
      .done     (done),
      .dbz      (dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int a, input int b, input int q, input int r);
      vec_t v;
      v.a = W'(a);
      v.b = W'(b);
      v.q = W'(q);
      v.r = W'(r);
      return v;
   endfunction

   // Reference model: SV integer division truncates toward zero.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      int ia;
      int ib;
      ia = int'(signed'(a));
      ib = int'(signed'(b));
      q  = W'(ia / ib);
      r  = W'(ia % ib);
   endfunction

   // Scoreboard consumer: compare every done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && done === 1'b1) begin
         dones++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 required no pending operation");
         end else begin
            e = sb.pop_front();
            if (e.chk_qr) begin
               chk("quot", 32'(quot), 32'(e.q));
               chk("rem", 32'(rem), 32'(e.r));
            end
            chk("dbz", 32'(dbz), 32'(e.dbz));
            chk("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   // Drive a request in the current cycle, then measure latency to done.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input bit chk_qr, input int glitch_at);
      exp_t e;
      int   lat;
      bit   seen;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      e.q = eq; e.r = er; e.dbz = edbz; e.chk_qr = chk_qr;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      lat  = 0;
      seen = 0;
      while (!seen && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (done === 1'b1) seen = 1;
         if (glitch_at != 0 && lat == glitch_at) begin
            start    = 1'b1;
            dividend = ~a;
            divisor  = W'(1);
         end else begin
            start = 1'b0;
         end
      end
      chk("latency", 32'(lat), 32'(W + 1));
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input bit chk_qr);
      @(negedge clk);
      launch(a, b, eq, er, edbz, chk_qr, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb, rq, rr;
      int           d0;

      vecs[0]  = mk( 13,   3,   4,  1);
      vecs[1]  = mk(-13,   3,  -4, -1);
      vecs[2]  = mk( 13,  -3,  -4,  1);
      vecs[3]  = mk(-16,  -1, -16,  0);
      vecs[4]  = mk(-16,   5,  -3, -1);
      vecs[5]  = mk(  0,   7,   0,  0);
      vecs[6]  = mk( 15,   1,  15,  0);
      vecs[7]  = mk( -1,   2,   0, -1);
      vecs[8]  = mk(  7, -16,   0,  7);
      vecs[9]  = mk(-16, -16,   1,  0);
      vecs[10] = mk(  9,   2,   4,  1);
      vecs[11] = mk( -7,  -2,   3, -1);
      vecs[12] = mk( 15, -16,   0, 15);
      vecs[13] = mk( 11,   4,   2,  3);

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_quot", 32'(quot), 32'd0);
      chk("reset_rem", 32'(rem), 32'd0);
      chk("reset_dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, 1'b1);
      end

      for (int i = 0; i < 8; i++) begin
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = W'($urandom_range(1, (1 << W) - 1));
         model(ra, rb, rq, rr);
         run_op(ra, rb, rq, rr, 1'b0, 1'b1);
      end

      // Start raised mid-operation with different operands must be ignored.
      @(negedge clk);
      launch(W'(13), W'(3), W'(4), W'(1), 1'b0, 1'b1, 2);
      // Back-to-back: accept the next request in the done cycle.
      launch(W'(-13), W'(3), W'(-4), W'(-1), 1'b0, 1'b1, 0);
      repeat (W + 3) @(posedge clk);
      #1;
      chk("no_extra_done", 32'(sb.size()), 32'd0);

      // Asynchronous reset in the middle of 9 / 2 aborts the operation.
      @(negedge clk);
      dividend = W'(9);
      divisor  = W'(2);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quot", 32'(quot), 32'd0);
      chk("abort_rem", 32'(rem), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      d0 = dones;
      repeat (W + 3) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(dones), 32'(d0));
      run_op(W'(9), W'(2), W'(4), W'(1), 1'b0, 1'b1);

`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
      run_op(W'(7), W'(0), 5'b11111, 5'b00111, 1'b1, 1'b1);
      run_op(W'(7), W'(7), W'(1), W'(0), 1'b0, 1'b1);
`else
      run_op(W'(7), W'(0), W'(0), W'(0), 1'b0, 1'b0);
      run_op(W'(7), W'(7), W'(1), W'(0), 1'b0, 1'b1);
`endif

      repeat (W + 3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
